rst_seq_ctrl: RTL and testbench
===============================

Name: rst_seq_ctrl

Overview:
Reset sequencer for the single system clock domain. It takes the already-synchronized global reset and releases NUM_DOMAINS subsystem resets in a fixed order, with a programmed hold time and a fixed step between releases. It also accepts software and watchdog reset requests at runtime, re-runs the sequence for them, and reports the cause of the last reset. It sits directly downstream of the reset synchronizer and drives the per-subsystem reset nets.

Parameters:
NUM_DOMAINS, 4, number of sequenced reset outputs (>=1).
HOLD_CYCLES, 16, cycles all domains are held in reset before the first release (>=1).
STEP_CYCLES, 8, cycles between successive domain releases (>=1).
CNT_WIDTH, 8, counter width; must satisfy 2^CNT_WIDTH > max(HOLD_CYCLES, STEP_CYCLES).

Ports:
CLK  input  1  system clock
RST  input  1  asynchronous active-low reset, driven from the synchronized reset output
SW_RST_REQ  input  1  software reset request, level-sampled each cycle
WDT_EXPIRE  input  1  watchdog expiry, level-sampled each cycle
DOMAIN_RST_N  output  NUM_DOMAINS  active-low per-domain resets; bit 0 is released first
RST_DONE  output  1  high when all domains are released
BUSY  output  1  high while a sequence is in progress
RST_CAUSE  output  2  cause of the last reset: 00 POR, 01 SW, 10 WDT, 11 unused

Behaviour:
- Clock and reset: one clock, CLK; asynchronous active-low reset, RST.
- While RST=0 (asynchronous):
  - state=HOLD, cnt=0, idx=0
  - DOMAIN_RST_N=all 0, RST_DONE=0, BUSY=1, RST_CAUSE=00
- States: HOLD, RELEASE, RUN. All outputs are registered; there is no combinational path from input to output.
- HOLD:
  - cnt increments each cycle.
  - When cnt==HOLD_CYCLES-1: go to RELEASE, cnt=0, idx=0.
- RELEASE:
  - cnt increments each cycle.
  - When cnt==STEP_CYCLES-1: set DOMAIN_RST_N[idx]=1, cnt=0, idx=idx+1.
  - If idx==NUM_DOMAINS-1 on that edge: go to RUN, with RST_DONE=1 and BUSY=0 on the same edge.
- RUN: hold all outputs. Any request sampled high causes a restart on that edge E.
- Restart on edge E:
  - state=HOLD, cnt=0, idx=0
  - DOMAIN_RST_N=all 0, RST_DONE=0, BUSY=1
  - RST_CAUSE latched: 10 if WDT_EXPIRE, else 01.
- Timing: counting the first edge after RST deassertion as edge 1 (E=0), domain k rises on edge E+HOLD_CYCLES+(k+1)*STEP_CYCLES.
- Simultaneous SW_RST_REQ and WDT_EXPIRE: WDT has priority; cause=10.
- During HOLD or RELEASE:
  - WDT_EXPIRE high restarts as above. Already-released domains are re-asserted, and cause=10.
  - SW_RST_REQ is ignored (not queued).
- A request held high continuously while in RUN restarts only on entry to RUN, then again on every cycle it is seen in RUN. The requester must pulse it.
- RST_CAUSE is sticky until the next reset event. RST low always forces 00.
- Release order is monotonic: DOMAIN_RST_N only has bits 0..idx-1 set at any time (thermometer pattern). Verification asserts this.
- cnt never wraps; the parameter check guarantees this. An illegal configuration is caught by an elaboration-time check.

Decomposition:
- Shared package rst_seq_pkg holds:
  - the state encoding (HOLD, RELEASE, RUN)
  - the cause codes (CAUSE_POR=00, CAUSE_SW=01, CAUSE_WDT=10)
- No sub-module. The counter and index are inline.
- The reset synchronizer is instantiated by the parent, not inside this block.

Test Plan:
- Power-on (defaults), RST low for 3 cycles then high, no requests -> DOMAIN_RST_N steps 0000→0001 at edge 24, →0011 at 32, →0111 at 40, →1111 at 48. RST_DONE rises at edge 48, BUSY falls at 48, RST_CAUSE=00.
- SW_RST_REQ pulsed 1 cycle in RUN at edge E -> at E: DOMAIN_RST_N=0000, BUSY=1, RST_CAUSE=01. Bit 0 released at E+24, all released at E+48.
- SW_RST_REQ and WDT_EXPIRE high together in RUN -> RST_CAUSE=10, sequence restarts.
- WDT_EXPIRE pulsed at edge 36 during power-on RELEASE, with DOMAIN_RST_N=0011 -> at edge 36: DOMAIN_RST_N=0000, cause=10. Bit 3 releases at edge 84.
- SW_RST_REQ pulsed during HOLD (edge 5) -> ignored, power-on timing unchanged, cause stays 00.
- RST asserted mid-RELEASE (DOMAIN_RST_N=0111) -> all outputs return to reset values immediately without a clock edge, and a fresh power-on sequence follows. Also repeat with NUM_DOMAINS=1, HOLD=1, STEP=1: domain released at edge 2.

Source files
------------

// File: rtl/rst_seq_pkg.sv
// Shared definitions for the reset sequencer.
//   state_t     : sequencer state encoding (HOLD, RELEASE, RUN)
//   CAUSE_*     : reset cause codes reported on RST_CAUSE
package rst_seq_pkg;

    typedef enum logic [1:0] {
        ST_HOLD    = 2'b00,
        ST_RELEASE = 2'b01,
        ST_RUN     = 2'b10
    } state_t;

    localparam logic [1:0] CAUSE_POR = 2'b00;
    localparam logic [1:0] CAUSE_SW  = 2'b01;
    localparam logic [1:0] CAUSE_WDT = 2'b10;

endpackage

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer for the system clock domain. Holds all subsystem resets
// for HOLD_CYCLES, then releases them one at a time every STEP_CYCLES,
// lowest index first. Software / watchdog requests re-run the sequence and
// the cause of the last reset is reported.
//
// Ports:
//   CLK          : system clock
//   RST          : async active-low reset (from the reset synchronizer)
//   SW_RST_REQ   : software reset request, level-sampled (honoured in RUN only)
//   WDT_EXPIRE   : watchdog expiry, level-sampled (honoured in any state)
//   DOMAIN_RST_N : active-low per-domain resets, bit 0 released first
//   RST_DONE     : all domains released
//   BUSY         : sequence in progress
//   RST_CAUSE    : 00 POR, 01 SW, 10 WDT
module rst_seq_ctrl
    import rst_seq_pkg::*;
#(
    parameter int NUM_DOMAINS = 4,
    parameter int HOLD_CYCLES = 16,
    parameter int STEP_CYCLES = 8,
    parameter int CNT_WIDTH   = 8
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   SW_RST_REQ,
    input  logic                   WDT_EXPIRE,
    output logic [NUM_DOMAINS-1:0] DOMAIN_RST_N,
    output logic                   RST_DONE,
    output logic                   BUSY,
    output logic [1:0]             RST_CAUSE
);

    localparam int IDX_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

    localparam logic [CNT_WIDTH-1:0] HOLD_LAST = CNT_WIDTH'(HOLD_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] STEP_LAST = CNT_WIDTH'(STEP_CYCLES - 1);
    localparam logic [IDX_W-1:0]     IDX_LAST  = IDX_W'(NUM_DOMAINS - 1);

    // Reject configurations where the counter could wrap before its compare.
    if (NUM_DOMAINS < 1 || HOLD_CYCLES < 1 || STEP_CYCLES < 1 ||
        HOLD_CYCLES > (2**CNT_WIDTH) - 1 || STEP_CYCLES > (2**CNT_WIDTH) - 1) begin : g_bad_cfg
        $error("rst_seq_ctrl: illegal parameter configuration");
    end

    state_t                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [NUM_DOMAINS-1:0] dom_d;
    logic                   done_d, busy_d;
    logic [1:0]             cause_d;
    logic                   restart;
    logic [NUM_DOMAINS-1:0] idx_bit;

    // One-hot of the next domain to release; OR-ing it into the current
    // pattern keeps DOMAIN_RST_N a thermometer code.
    always_comb begin
        for (int i = 0; i < NUM_DOMAINS; i++) begin
            idx_bit[i] = (idx_q == IDX_W'(i));
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q      <= ST_HOLD;
            cnt_q        <= '0;
            idx_q        <= '0;
            DOMAIN_RST_N <= '0;
            RST_DONE     <= 1'b0;
            BUSY         <= 1'b1;
            RST_CAUSE    <= CAUSE_POR;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            DOMAIN_RST_N <= dom_d;
            RST_DONE     <= done_d;
            BUSY         <= busy_d;
            RST_CAUSE    <= cause_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        dom_d   = DOMAIN_RST_N;
        done_d  = RST_DONE;
        busy_d  = BUSY;
        cause_d = RST_CAUSE;
        restart = 1'b0;

        unique case (state_q)
            ST_HOLD: begin
                // Only the watchdog can interrupt a sequence; SW requests are dropped.
                if (WDT_EXPIRE) begin
                    restart = 1'b1;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = ST_RELEASE;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            ST_RELEASE: begin
                if (WDT_EXPIRE) begin
                    restart = 1'b1;
                end else if (cnt_q == STEP_LAST) begin
                    dom_d = DOMAIN_RST_N | idx_bit;
                    cnt_d = '0;
                    if (idx_q == IDX_LAST) begin
                        state_d = ST_RUN;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            ST_RUN: begin
                if (SW_RST_REQ || WDT_EXPIRE) restart = 1'b1;
            end
            default: restart = 1'b1;
        endcase

        if (restart) begin
            state_d = ST_HOLD;
            cnt_d   = '0;
            idx_d   = '0;
            dom_d   = '0;
            done_d  = 1'b0;
            busy_d  = 1'b1;
            cause_d = WDT_EXPIRE ? CAUSE_WDT : CAUSE_SW;
        end
    end

endmodule

// File: tb/tb_rst_seq_ctrl.sv
module tb_rst_seq_ctrl;

    localparam int N = 4;
    localparam int H = 16;
    localparam int S = 8;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Default-configuration DUT
    logic       rst_n = 1'b0, sw = 1'b0, wdt = 1'b0;
    logic [3:0] dom;
    logic       done, busy;
    logic [1:0] cause;

    rst_seq_ctrl #(.NUM_DOMAINS(N), .HOLD_CYCLES(H), .STEP_CYCLES(S), .CNT_WIDTH(8)) dut0 (
        .CLK(CLK), .RST(rst_n), .SW_RST_REQ(sw), .WDT_EXPIRE(wdt),
        .DOMAIN_RST_N(dom), .RST_DONE(done), .BUSY(busy), .RST_CAUSE(cause)
    );

    // Minimal configuration DUT: 1 domain, hold 1, step 1
    logic       rst1_n = 1'b0, sw1 = 1'b0, wdt1 = 1'b0;
    logic [0:0] dom1;
    logic       done1, busy1;
    logic [1:0] cause1;

    rst_seq_ctrl #(.NUM_DOMAINS(1), .HOLD_CYCLES(1), .STEP_CYCLES(1), .CNT_WIDTH(8)) dut1 (
        .CLK(CLK), .RST(rst1_n), .SW_RST_REQ(sw1), .WDT_EXPIRE(wdt1),
        .DOMAIN_RST_N(dom1), .RST_DONE(done1), .BUSY(busy1), .RST_CAUSE(cause1)
    );

    typedef struct packed {
        logic [3:0] dom;
        logic       done;
        logic       busy;
        logic [1:0] cause;
    } obs_t;

    typedef struct {
        int    scn;
        int    edge_n;
        int    len;
        bit    sw;
        bit    wdt;
        obs_t  expv;
        string name;
    } vec_t;

    vec_t tbl[$];
    obs_t sb[$];
    int   total = 0;
    int   bad   = 0;

    function automatic obs_t cur0();
        return {dom, done, busy, cause};
    endfunction

    function automatic obs_t cur1();
        return {3'b000, dom1, done1, busy1, cause1};
    endfunction

    function void add(int scn, int e, int len, bit s, bit w,
                      logic [3:0] d, bit dn, bit b, logic [1:0] c, string nm);
        vec_t v;
        v.scn = scn; v.edge_n = e; v.len = len; v.sw = s; v.wdt = w;
        v.expv = {d, dn, b, c}; v.name = nm;
        tbl.push_back(v);
    endfunction

    task automatic check(string nm, obs_t got, obs_t expv);
        total++;
        if (got !== expv) begin
            bad++;
            $display("FAIL %s: got dom=%b done=%b busy=%b cause=%b, expected dom=%b done=%b busy=%b cause=%b",
                     nm, got.dom, got.done, got.busy, got.cause,
                     expv.dom, expv.done, expv.busy, expv.cause);
        end
    endtask

    // Expected outputs rel edges after the last (re)start, from the release
    // timetable: domain k rises at rel = H + (k+1)*S.
    function automatic obs_t model(int rel, logic [1:0] c);
        obs_t o;
        o.dom = '0;
        for (int k = 0; k < N; k++) if (rel >= H + (k + 1) * S) o.dom[k] = 1'b1;
        o.done  = (rel >= H + N * S);
        o.busy  = !o.done;
        o.cause = c;
        return o;
    endfunction

    // Thermometer property on the default DUT
    always @(negedge CLK) begin
        logic [3:0] p;
        if (rst_n) begin
            p = dom + 4'd1;
            total++;
            if ((p & dom) !== 4'b0000) begin
                bad++;
                $display("FAIL thermometer: dom=%b", dom);
            end
        end
    end

    // Assert RST mid-cycle and verify reset values without any clock edge,
    // then hold for 3 cycles and release on a falling edge.
    task automatic do_reset(string tag);
        @(posedge CLK);
        #1;
        rst_n = 1'b0; sw = 1'b0; wdt = 1'b0;
        #1;
        check({tag, "_async"}, cur0(), {4'b0000, 1'b0, 1'b1, 2'b00});
        repeat (3) @(negedge CLK);
        rst_n = 1'b1;
    endtask

    // Drive edges 1..last of scenario scn: stimulus and checkpoints come from
    // the table, and every edge is also compared against the timetable model
    // through the scoreboard queue.
    task automatic run_scn(int scn, int last, string tag);
        int         start = 0;
        logic [1:0] mc = 2'b00;
        bit         s, w, in_run;
        obs_t       e, got;
        for (int t = 1; t <= last; t++) begin
            s = 1'b0; w = 1'b0;
            foreach (tbl[i])
                if (tbl[i].scn == scn && t >= tbl[i].edge_n && t < tbl[i].edge_n + tbl[i].len) begin
                    s |= tbl[i].sw;
                    w |= tbl[i].wdt;
                end
            sw = s; wdt = w;
            in_run = (t - 1 - start) >= H + N * S;
            if ((in_run && (s || w)) || (!in_run && w)) begin
                start = t;
                mc = w ? 2'b10 : 2'b01;
            end
            sb.push_back(model(t - start, mc));
            @(posedge CLK);
            #1;
            got = cur0();
            e = sb.pop_front();
            check($sformatf("%s_model_e%0d", tag, t), got, e);
            foreach (tbl[i])
                if (tbl[i].scn == scn && tbl[i].edge_n == t)
                    check($sformatf("%s_%s_e%0d", tag, tbl[i].name, t), got, tbl[i].expv);
            @(negedge CLK);
        end
        sw = 1'b0; wdt = 1'b0;
    endtask

    initial begin
        // Scenario 0: power-on, SW in HOLD (ignored), SW in RUN, SW+WDT in RUN
        add(0,   5, 1, 1, 0, 4'b0000, 0, 1, 2'b00, "sw_in_hold");
        add(0,  23, 1, 0, 0, 4'b0000, 0, 1, 2'b00, "por_pre0");
        add(0,  24, 1, 0, 0, 4'b0001, 0, 1, 2'b00, "por_d0");
        add(0,  32, 1, 0, 0, 4'b0011, 0, 1, 2'b00, "por_d1");
        add(0,  40, 1, 0, 0, 4'b0111, 0, 1, 2'b00, "por_d2");
        add(0,  47, 1, 0, 0, 4'b0111, 0, 1, 2'b00, "por_pre3");
        add(0,  48, 1, 0, 0, 4'b1111, 1, 0, 2'b00, "por_done");
        add(0,  60, 1, 1, 0, 4'b0000, 0, 1, 2'b01, "sw_run");
        add(0,  83, 1, 0, 0, 4'b0000, 0, 1, 2'b01, "sw_pre0");
        add(0,  84, 1, 0, 0, 4'b0001, 0, 1, 2'b01, "sw_d0");
        add(0, 108, 1, 0, 0, 4'b1111, 1, 0, 2'b01, "sw_done");
        add(0, 120, 1, 1, 1, 4'b0000, 0, 1, 2'b10, "both_run");
        add(0, 144, 1, 0, 0, 4'b0001, 0, 1, 2'b10, "both_d0");
        add(0, 168, 1, 0, 0, 4'b1111, 1, 0, 2'b10, "both_done");
        // Scenario 1: watchdog during power-on RELEASE
        add(1,  35, 1, 0, 0, 4'b0011, 0, 1, 2'b00, "wdt_pre");
        add(1,  36, 1, 0, 1, 4'b0000, 0, 1, 2'b10, "wdt_release");
        add(1,  60, 1, 0, 0, 4'b0001, 0, 1, 2'b10, "wdt_d0");
        add(1,  83, 1, 0, 0, 4'b0111, 0, 1, 2'b10, "wdt_pre3");
        add(1,  84, 1, 0, 0, 4'b1111, 1, 0, 2'b10, "wdt_done");
        // Scenario 2: SW held high for edges 1..50
        add(2,   1, 50, 1, 0, 4'b0000, 0, 1, 2'b00, "held_hold");
        add(2,  48, 1, 0, 0, 4'b1111, 1, 0, 2'b00, "held_release");
        add(2,  49, 1, 0, 0, 4'b0000, 0, 1, 2'b01, "held_run");
        add(2,  50, 1, 0, 0, 4'b0000, 0, 1, 2'b01, "held_hold2");
        add(2,  97, 1, 0, 0, 4'b1111, 1, 0, 2'b01, "held_done");
        // Scenario 3: run into RELEASE before an async reset
        add(3,  45, 1, 0, 0, 4'b0111, 0, 1, 2'b00, "pre_async");
        // Scenario 4: fresh power-on after the async reset
        add(4,  24, 1, 0, 0, 4'b0001, 0, 1, 2'b00, "repor_d0");
        add(4,  48, 1, 0, 0, 4'b1111, 1, 0, 2'b00, "repor_done");

        do_reset("rst0");
        run_scn(0, 172, "por");
        do_reset("rst1");
        run_scn(1, 88, "wdt");
        do_reset("rst2");
        run_scn(2, 100, "held");
        do_reset("rst3");
        run_scn(3, 45, "mid");
        do_reset("rst4");
        run_scn(4, 50, "repor");

        // Minimal configuration: domain released at edge 2
        @(negedge CLK);
        check("min_rst", cur1(), {4'b0000, 1'b0, 1'b1, 2'b00});
        rst1_n = 1'b1;
        @(posedge CLK); #1;
        check("min_e1", cur1(), {4'b0000, 1'b0, 1'b1, 2'b00});
        @(posedge CLK); #1;
        check("min_e2", cur1(), {4'b0001, 1'b1, 1'b0, 2'b00});
        @(negedge CLK); sw1 = 1'b1;
        @(posedge CLK); #1;
        check("min_sw_e3", cur1(), {4'b0000, 1'b0, 1'b1, 2'b01});
        @(negedge CLK); sw1 = 1'b0;
        @(posedge CLK); #1;
        check("min_e4", cur1(), {4'b0000, 1'b0, 1'b1, 2'b01});
        @(posedge CLK); #1;
        check("min_e5", cur1(), {4'b0001, 1'b1, 1'b0, 2'b01});
        @(posedge CLK); #1;
        rst1_n = 1'b0;
        #1;
        check("min_async", cur1(), {4'b0000, 1'b0, 1'b1, 2'b00});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
